// File: rtl/rpn_pkg.sv
// rpn_pkg: shared definitions for the reverse-Polish evaluator.
//   - opcode encodings carried in tok_data[2:0]
//   - error codes reported on err_code
//   - evaluator FSM state type
package rpn_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_EMIT = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_OP   = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    PUSH,
    POP_B,
    POP_A,
    LOAD_A,
    WB,
    EPOP,
    ELOAD,
    OUT,
    ERR
  } rpn_state_t;

  // Binary operators occupy the contiguous range ADD..XOR.
  function automatic logic is_binop(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational ALU for the evaluator.
//   a  : second-popped operand
//   b  : first-popped operand (top of stack)
//   op : opcode (ADD, SUB, AND, OR, XOR); other codes yield zero
//   y  : result, modulo 2^W
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/stack.sv
// stack: LIFO with registered read data.
//   clk, reset   : clock, synchronous active-low reset
//   push, din    : write din on top when not full
//   pop          : remove top when not empty; value appears on data_out
//                  on the cycle after the pop
//   full, empty  : occupancy flags
module stack #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] data_out,
  output logic         full,
  output logic         empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [DW-1:0] r_sp;
  logic [W-1:0]  r_dout;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sp   <= '0;
      r_dout <= '0;
    end else if (push && !full) begin
      r_mem[AW'(r_sp)] <= din;
      r_sp             <= r_sp + DW'(1);
    end else if (pop && !empty) begin
      r_dout <= r_mem[AW'(r_sp - DW'(1))];
      r_sp   <= r_sp - DW'(1);
    end
  end

  assign data_out = r_dout;
  assign full     = (r_sp == DW'(DEPTH));
  assign empty    = (r_sp == '0);

endmodule

// File: rtl/rpn_eval.sv
// rpn_eval: reverse-Polish evaluator driving an external stack.
//   clk, reset                    : clock, synchronous active-low reset
//   tok_valid/tok_ready           : token handshake
//   tok_is_op, tok_data           : opcode flag and operand/opcode value
//   res_valid/res_ready, res_data : emitted-result handshake
//   stk_push, stk_pop, stk_din    : stack command outputs
//   stk_dout, stk_full, stk_empty : stack status inputs (dout registered)
//   depth                         : tracked stack occupancy
//   err, err_code                 : sticky error flag and first error code
module rpn_eval
  import rpn_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tok_valid,
  output logic                         tok_ready,
  input  logic                         tok_is_op,
  input  logic [W-1:0]                 tok_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [W-1:0]                 res_data,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [W-1:0]                 stk_din,
  input  logic [W-1:0]                 stk_dout,
  input  logic                         stk_full,
  input  logic                         stk_empty,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         err,
  output logic [1:0]                   err_code
);

  localparam int DW = $clog2(DEPTH + 1);

  rpn_state_t    r_state, w_next;
  logic [W-1:0]  r_opnd, r_a, r_b, r_res;
  logic [2:0]    r_op;
  logic [DW-1:0] r_depth;
  logic [1:0]    r_err_code, w_err_code;
  logic [2:0]    w_tok_op;
  logic [W-1:0]  w_alu_y;

  assign w_tok_op = tok_data[2:0];

  rpn_alu #(.W(W)) u_alu (
    .a  (r_a),
    .b  (r_b),
    .op (r_op),
    .y  (w_alu_y)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_depth    <= '0;
      r_err_code <= ERR_NONE;
      r_opnd     <= '0;
      r_op       <= OP_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
    end else begin
      r_state <= w_next;
      // ERR is only entered from IDLE and never left, so the first code sticks.
      if (r_state == IDLE && w_next == ERR) r_err_code <= w_err_code;
      if (r_state == IDLE && tok_valid) begin
        r_opnd <= tok_data;
        r_op   <= w_tok_op;
      end
      case (r_state)
        PUSH:    r_depth <= r_depth + DW'(1);
        POP_A:   r_b     <= stk_dout;
        LOAD_A:  r_a     <= stk_dout;
        WB:      r_depth <= r_depth - DW'(1);
        EPOP:    r_depth <= r_depth - DW'(1);
        ELOAD:   r_res   <= stk_dout;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    w_err_code = ERR_NONE;
    tok_ready  = 1'b0;
    res_valid  = 1'b0;
    err        = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_din    = '0;

    case (r_state)
      IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          if (!tok_is_op) begin
            if (r_depth == DW'(DEPTH) || stk_full) begin
              w_next     = ERR;
              w_err_code = ERR_OVF;
            end else begin
              w_next = PUSH;
            end
          end else if (is_binop(w_tok_op)) begin
            if (r_depth < DW'(2)) begin
              w_next     = ERR;
              w_err_code = ERR_UNF;
            end else begin
              w_next = POP_B;
            end
          end else if (w_tok_op == OP_EMIT) begin
            if (r_depth == '0 || stk_empty) begin
              w_next     = ERR;
              w_err_code = ERR_UNF;
            end else begin
              w_next = EPOP;
            end
          end else begin
            w_next     = ERR;
            w_err_code = ERR_OP;
          end
        end
      end
      PUSH: begin
        stk_push = 1'b1;
        stk_din  = r_opnd;
        w_next   = IDLE;
      end
      POP_B: begin
        stk_pop = 1'b1;
        w_next  = POP_A;
      end
      POP_A: begin
        stk_pop = 1'b1;
        w_next  = LOAD_A;
      end
      LOAD_A: w_next = WB;
      WB: begin
        stk_push = 1'b1;
        stk_din  = w_alu_y;
        w_next   = IDLE;
      end
      EPOP: begin
        stk_pop = 1'b1;
        w_next  = ELOAD;
      end
      ELOAD: w_next = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) w_next = IDLE;
      end
      ERR: begin
        tok_ready = 1'b1;
        err       = 1'b1;
      end
      default: w_next = IDLE;
    endcase

    // Reset aborts stack traffic on the very cycle it is asserted.
    if (!reset) begin
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      stk_din  = '0;
    end
  end

  assign depth    = r_depth;
  assign res_data = r_res;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_rpn_eval.sv
module tb_rpn_eval;
  import rpn_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic          tok_is_op = 1'b0;
  logic [W-1:0]  tok_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [W-1:0]  res_data;
  logic          stk_push, stk_pop;
  logic [W-1:0]  stk_din, stk_dout;
  logic          stk_full, stk_empty;
  logic [DW-1:0] depth;
  logic          err;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  rpn_eval #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_is_op (tok_is_op),
    .tok_data  (tok_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .depth     (depth),
    .err       (err),
    .err_code  (err_code)
  );

  stack #(.DEPTH(DEPTH), .W(W)) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (stk_push),
    .pop      (stk_pop),
    .din      (stk_din),
    .data_out (stk_dout),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned push_cnt = 0;
  int unsigned pop_cnt  = 0;
  logic [W-1:0] model [$];
  logic [W-1:0] sb [$];

  always @(posedge clk) begin
    if (stk_push) push_cnt <= push_cnt + 1;
    if (stk_pop)  pop_cnt  <= pop_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle after acceptance.
  task automatic send(input logic is_op, input logic [W-1:0] d);
    int unsigned n = 0;
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = d;
    while (!tok_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("send_tok_ready_timeout", {31'b0, tok_ready}, 1);
    @(negedge clk);
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_data  = '0;
  endtask

  task automatic wait_ready(output int unsigned c);
    c = 1;
    while (!tok_ready && c < 64) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    tok_valid = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model.delete();
    sb.delete();
  endtask

  task automatic do_push(input logic [W-1:0] v, output int unsigned lat);
    model.push_back(v);
    send(1'b0, v);
    wait_ready(lat);
    check("depth_after_push", 32'(depth), 32'(model.size()));
  endtask

  task automatic do_bin(input logic [2:0] op, output int unsigned lat);
    logic [W-1:0] a, b, y;
    b = model.pop_back();
    a = model.pop_back();
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = a ^ b;
    endcase
    model.push_back(y);
    send(1'b1, W'(op));
    wait_ready(lat);
    check("depth_after_binop", 32'(depth), 32'(model.size()));
  endtask

  task automatic get_result(input string tag);
    int unsigned n = 0;
    logic [W-1:0] exp;
    while (!res_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'b0, res_valid}, 1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check(tag, 32'(res_data), 32'(exp));
    end
    @(negedge clk);
  endtask

  task automatic do_emit(input string tag, output int unsigned lat);
    int unsigned c;
    sb.push_back(model.pop_back());
    send(1'b1, W'(OP_EMIT));
    lat = 1;
    while (!res_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    get_result(tag);
    wait_ready(c);
    check({tag, "_depth"}, 32'(depth), 32'(model.size()));
  endtask

  initial begin
    int unsigned lat;
    int unsigned p0, q0;

    // Reset values
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tok_ready", {31'b0, tok_ready}, 1);
    check("rst_depth",     32'(depth), 0);
    check("rst_err",       {31'b0, err}, 0);
    check("rst_err_code",  32'(err_code), 0);
    check("rst_push_pop",  {30'b0, stk_push, stk_pop}, 0);
    check("rst_res_valid", {31'b0, res_valid}, 0);
    check("rst_res_data",  32'(res_data), 0);
    check("rst_stk_din",   32'(stk_din), 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_tok_ready", {31'b0, tok_ready}, 1);

    // 3 4 ADD EMIT with latency checks
    do_push(8'h03, lat);
    check("lat_operand", lat, 2);
    do_push(8'h04, lat);
    check("depth_two", 32'(depth), 2);
    do_bin(OP_ADD, lat);
    check("lat_binop", lat, 5);
    check("depth_one", 32'(depth), 1);
    do_emit("emit_add", lat);
    check("lat_emit_valid", lat, 3);
    check("depth_zero", 32'(depth), 0);

    // SUB wrap, XOR, AND, OR
    do_push(8'h05, lat);
    do_push(8'h09, lat);
    do_bin(OP_SUB, lat);
    do_emit("emit_sub", lat);
    do_push(8'hAA, lat);
    do_push(8'h0F, lat);
    do_bin(OP_XOR, lat);
    do_emit("emit_xor", lat);
    do_push(8'hF0, lat);
    do_push(8'h3C, lat);
    do_bin(OP_AND, lat);
    do_emit("emit_and", lat);
    do_push(8'h81, lat);
    do_push(8'h02, lat);
    do_bin(OP_OR, lat);
    do_emit("emit_or", lat);

    // Result back-pressure
    do_push(8'h10, lat);
    do_push(8'h20, lat);
    res_ready = 1'b0;
    sb.push_back(model.pop_back());
    send(1'b1, W'(OP_EMIT));
    lat = 1;
    while (!res_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 4; i++) begin
      check("bp_res_valid", {31'b0, res_valid}, 1);
      check("bp_res_data",  32'(res_data), 32'h20);
      check("bp_tok_ready", {31'b0, tok_ready}, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    get_result("bp_emit");
    wait_ready(lat);
    do_emit("emit_after_bp", lat);

    // Overflow on the ninth operand
    do_reset();
    for (int i = 0; i < 8; i++) do_push(W'(8'h40 + i), lat);
    check("ovf_full", {31'b0, stk_full}, 1);
    p0 = push_cnt;
    send(1'b0, 8'hEE);
    @(negedge clk);
    check("ovf_err",      {31'b0, err}, 1);
    check("ovf_err_code", 32'(err_code), 32'(ERR_OVF));
    check("ovf_depth",    32'(depth), 8);
    check("ovf_no_push",  push_cnt, p0);
    q0 = pop_cnt;
    send(1'b0, 8'h01);
    send(1'b1, W'(OP_ADD));
    send(1'b1, 8'h05);
    send(1'b1, W'(OP_EMIT));
    repeat (3) @(negedge clk);
    check("err_absorb_push", push_cnt, p0);
    check("err_absorb_pop",  pop_cnt, q0);
    check("err_first_wins",  32'(err_code), 32'(ERR_OVF));
    check("err_tok_ready",   {31'b0, tok_ready}, 1);

    // Underflow: ADD with one entry
    do_reset();
    do_push(8'h11, lat);
    p0 = push_cnt;
    q0 = pop_cnt;
    send(1'b1, W'(OP_ADD));
    @(negedge clk);
    check("unf_err_code", 32'(err_code), 32'(ERR_UNF));
    check("unf_depth",    32'(depth), 1);
    check("unf_no_traffic", push_cnt + pop_cnt, p0 + q0);

    // Underflow: EMIT on empty
    do_reset();
    send(1'b1, W'(OP_EMIT));
    @(negedge clk);
    check("emit_empty_err_code", 32'(err_code), 32'(ERR_UNF));

    // Illegal opcode
    do_reset();
    send(1'b1, 8'h05);
    @(negedge clk);
    check("badop_err",      {31'b0, err}, 1);
    check("badop_err_code", 32'(err_code), 32'(ERR_OP));

    // Reset during POP_A of an ADD
    do_reset();
    do_push(8'h01, lat);
    do_push(8'h02, lat);
    p0 = push_cnt;
    q0 = pop_cnt;
    send(1'b1, W'(OP_ADD));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_no_pop",  {31'b0, stk_pop}, 0);
    check("rst_mid_no_push", {31'b0, stk_push}, 0);
    @(negedge clk);
    check("rst_mid_tok_ready", {31'b0, tok_ready}, 1);
    check("rst_mid_depth",     32'(depth), 0);
    check("rst_mid_push_cnt",  push_cnt, p0);
    check("rst_mid_pop_cnt",   pop_cnt, q0 + 1);
    reset = 1'b1;
    model.delete();
    sb.delete();
    @(negedge clk);
    check("rst_mid_stk_empty", {31'b0, stk_empty}, 1);
    do_push(8'h06, lat);
    do_push(8'h07, lat);
    do_bin(OP_ADD, lat);
    do_emit("emit_after_rst", lat);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
